// File: rtl/resp_capture_pkg.sv
// resp_capture_pkg: shared state encoding, default MISR constants and the MISR step function
// Revision: 1.0
`default_nettype none

package resp_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] C_DEF_POLY = 16'h1021;
    localparam logic [15:0] C_DEF_SEED = 16'h0000;

    // Operands are zero-extended to 64 bits so one function serves any SIG_W <= 64.
    function automatic logic [63:0] misr_step(
        input logic [63:0] sig,
        input logic [63:0] resp,
        input logic [63:0] poly,
        input int unsigned width
    );
        logic [63:0] w_mask;
        logic        w_fb;
        w_mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        w_fb   = ((sig >> (width - 1)) & 64'd1) != 64'd0;
        return ((sig << 1) ^ (w_fb ? poly : 64'd0) ^ resp) & w_mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/resp_misr.sv
// resp_misr: signature register with seed load and per-beat MISR step
// Revision: 1.0
`default_nettype none

module resp_misr
    import resp_capture_pkg::*;
#(
    parameter int                RESP_W = 8,
    parameter int                SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = SIG_W'(C_DEF_POLY),
    parameter logic [SIG_W-1:0]  SEED   = SIG_W'(C_DEF_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_en,
    input  logic [RESP_W-1:0] i_resp,
    output logic [SIG_W-1:0]  o_sig_next
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_base;

    // A load coincident with a step means the step must start from SEED.
    assign w_base     = i_load ? SEED : r_sig;
    assign o_sig_next = SIG_W'(misr_step(64'(w_base), 64'(i_resp), 64'(POLY), SIG_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= o_sig_next;
        end else if (i_load) begin
            r_sig <= SEED;
        end
    end

endmodule

`default_nettype wire

// File: rtl/resp_misr_capture.sv
// resp_misr_capture: compacts handshaked netlist responses into a MISR signature per burst.
// Optional GOLDEN_CHECK_EN adds golden_sig input and registered out_pass result.  Revision: 1.0
`default_nettype none

module resp_misr_capture
    import resp_capture_pkg::*;
#(
    parameter int                RESP_W = 8,
    parameter int                SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = SIG_W'(C_DEF_POLY),
    parameter logic [SIG_W-1:0]  SEED   = SIG_W'(C_DEF_SEED),
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RESP_W-1:0] in_resp,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIG_W-1:0]  out_sig,
    output logic [CNT_W-1:0]  out_count,
`ifdef GOLDEN_CHECK_EN
    input  logic [SIG_W-1:0]  golden_sig,
    output logic              out_pass,
`endif
    output logic              busy
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;
    logic [SIG_W-1:0] w_sig_next;
    logic [SIG_W-1:0] r_out_sig;
    logic [CNT_W-1:0] r_out_count;
    logic             w_accept;
    logic             w_load;
    logic             w_finish;

    assign in_ready  = (r_state != DONE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == ACCUM);
    assign out_sig   = r_out_sig;
    assign out_count = r_out_count;

    assign w_accept = in_valid && in_ready;
    assign w_finish = w_accept && in_last;
    // IDLE starts each burst from SEED; a DONE handshake reloads it for the next one.
    assign w_load   = (r_state == IDLE) || ((r_state == DONE) && out_ready);

    assign w_cnt_base = (r_state == IDLE) ? '0 : r_cnt;
    assign w_cnt_next = (&w_cnt_base) ? w_cnt_base : w_cnt_base + 1'b1;

    resp_misr #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_en       (w_accept),
        .i_resp     (in_resp),
        .o_sig_next (w_sig_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_finish) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_next;
        end else if ((r_state == DONE) && out_ready) begin
            r_cnt <= '0;
        end
    end

    // Result registers are only written on DONE entry, so they stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_sig   <= '0;
            r_out_count <= '0;
        end else if (w_finish) begin
            r_out_sig   <= w_sig_next;
            r_out_count <= w_cnt_next;
        end
    end

`ifdef GOLDEN_CHECK_EN
    logic r_pass;

    assign out_pass = r_pass;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else if (w_finish) begin
            r_pass <= (w_sig_next == golden_sig);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_resp_misr_capture.sv
// tb_resp_misr_capture: two instances (SEED=0/CNT_W=16 and SEED=8000/CNT_W=2) on shared stimulus,
// checked each cycle against a burst-queue reference model.  Revision: 1.0
`default_nettype none

module tb_resp_misr_capture;

    localparam logic [15:0] POLY_M = 16'h1021;

    typedef logic [7:0] beat_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_resp = 8'h00;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, busy_a;
    logic [15:0] out_sig_a;
    logic [15:0] out_count_a;
    logic        in_ready_b, out_valid_b, busy_b;
    logic [15:0] out_sig_b;
    logic [1:0]  out_count_b;
`ifdef GOLDEN_CHECK_EN
    logic [15:0] golden_a = 16'h0;
    logic [15:0] golden_b = 16'h0;
    logic        out_pass_a, out_pass_b;
`endif

    int checks = 0;
    int errors = 0;
    bit flip   = 1'b0;

    always #5 clk = ~clk;

    resp_misr_capture u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_a),
        .in_resp    (in_resp),
        .in_last    (in_last),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .out_sig    (out_sig_a),
        .out_count  (out_count_a),
`ifdef GOLDEN_CHECK_EN
        .golden_sig (golden_a),
        .out_pass   (out_pass_a),
`endif
        .busy       (busy_a)
    );

    resp_misr_capture #(
        .SEED  (16'h8000),
        .CNT_W (2)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_b),
        .in_resp    (in_resp),
        .in_last    (in_last),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .out_sig    (out_sig_b),
        .out_count  (out_count_b),
`ifdef GOLDEN_CHECK_EN
        .golden_sig (golden_b),
        .out_pass   (out_pass_b),
`endif
        .busy       (busy_b)
    );

    // Reference: shift-register as polynomial arithmetic over an int, folded over a whole burst.
    function automatic logic [15:0] fold(input logic [15:0] seed, input beat_q_t q);
        int s;
        s = int'(seed);
        foreach (q[i]) begin
            s = s * 2;
            if (s >= 65536) s = (s - 65536) ^ int'(POLY_M);
            s = s ^ int'(q[i]);
        end
        return 16'(s);
    endfunction

    beat_q_t     m_q;
    bit          m_res_v   = 1'b0;
    bit          m_ever    = 1'b0;
    bit          m_started = 1'b0;
    logic [15:0] m_sig[2];
    int          m_cnt[2];
    bit          m_pass[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_started = 1'b1;
        if (rst) begin
            m_q.delete();
            m_res_v = 1'b0;
            m_ever  = 1'b0;
        end else if (m_res_v) begin
            if (out_ready) m_res_v = 1'b0;
        end else if (in_valid) begin
            m_q.push_back(in_resp);
            if (in_last) begin
                m_sig[0] = fold(16'h0000, m_q);
                m_sig[1] = fold(16'h8000, m_q);
                m_cnt[0] = (m_q.size() > 65535) ? 65535 : m_q.size();
                m_cnt[1] = (m_q.size() > 3) ? 3 : m_q.size();
`ifdef GOLDEN_CHECK_EN
                m_pass[0] = (m_sig[0] == golden_a);
                m_pass[1] = (m_sig[1] == golden_b);
`else
                m_pass[0] = 1'b0;
                m_pass[1] = 1'b0;
`endif
                m_res_v = 1'b1;
                m_ever  = 1'b1;
                m_q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready_a",  {31'b0, in_ready_a},  {31'b0, !m_res_v});
            chk("in_ready_b",  {31'b0, in_ready_b},  {31'b0, !m_res_v});
            chk("out_valid_a", {31'b0, out_valid_a}, {31'b0, m_res_v});
            chk("out_valid_b", {31'b0, out_valid_b}, {31'b0, m_res_v});
            chk("busy_a", {31'b0, busy_a}, {31'b0, (m_q.size() != 0)});
            chk("busy_b", {31'b0, busy_b}, {31'b0, (m_q.size() != 0)});
            if (m_res_v || !m_ever) begin
                chk("out_sig_a",   32'(out_sig_a),   m_res_v ? 32'(m_sig[0]) : 32'd0);
                chk("out_sig_b",   32'(out_sig_b),   m_res_v ? 32'(m_sig[1]) : 32'd0);
                chk("out_count_a", 32'(out_count_a), m_res_v ? 32'(m_cnt[0]) : 32'd0);
                chk("out_count_b", 32'(out_count_b), m_res_v ? 32'(m_cnt[1]) : 32'd0);
`ifdef GOLDEN_CHECK_EN
                chk("out_pass_a", {31'b0, out_pass_a}, m_res_v ? {31'b0, m_pass[0]} : 32'd0);
                chk("out_pass_b", {31'b0, out_pass_b}, m_res_v ? {31'b0, m_pass[1]} : 32'd0);
`endif
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] r, input bit l, input bit ordy, input bit rs = 1'b0);
        beat_q_t tq;
        @(posedge clk);
        #1;
        rst       = rs;
        in_valid  = v;
        in_resp   = r;
        in_last   = l;
        out_ready = ordy;
        tq = m_q;
        tq.push_back(r);
`ifdef GOLDEN_CHECK_EN
        golden_a = fold(16'h0000, tq) ^ {15'b0, flip};
        golden_b = fold(16'h8000, tq) ^ {flip, 15'b0};
`endif
    endtask

    task automatic pin(input logic [15:0] sig_a, input int cnt_a, input int cnt_b);
        @(negedge clk);
        chk("pin_valid",     {31'b0, out_valid_a}, 32'd1);
        chk("pin_model_sig", 32'(m_sig[0]),  32'(sig_a));
        chk("pin_sig_a",     32'(out_sig_a),   32'(sig_a));
        chk("pin_cnt_a",     32'(out_count_a), 32'(cnt_a));
        chk("pin_cnt_b",     32'(out_count_b), 32'(cnt_b));
`ifdef GOLDEN_CHECK_EN
        chk("pin_pass_a",    {31'b0, out_pass_a}, {31'b0, !flip});
        chk("pin_pass_b",    {31'b0, out_pass_b}, {31'b0, !flip});
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0);
        @(negedge clk);
        chk("reset_sig",      32'(out_sig_a), 32'd0);
        chk("reset_in_ready", {31'b0, in_ready_a}, 32'd1);

        // single zero beat: SEED=0 stays 0, SEED=8000 exercises the feedback tap
        cyc(1, 8'h00, 1, 1);
        cyc(0, 8'h00, 0, 1);
        pin(16'h0000, 1, 1);
        chk("tap_model_sig_b", 32'(m_sig[1]),  32'h1021);
        chk("tap_sig_b",       32'(out_sig_b), 32'h1021);

        cyc(1, 8'h01, 1, 1);
        cyc(0, 8'h00, 0, 1);
        pin(16'h0001, 1, 1);

        // two beats, then stalled beats under backpressure
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'hAA, 1, 0);
        pin(16'h0000, 2, 2);
        cyc(1, 8'h01, 1, 1);
        cyc(1, 8'h01, 1, 1);
        cyc(0, 8'h00, 0, 0);
        pin(16'h0001, 1, 1);
        cyc(0, 8'h00, 0, 1);

        // reset in the middle of a burst discards it
        for (int i = 0; i < 3; i++) cyc(1, 8'h11, 0, 0);
        cyc(0, 8'h00, 0, 0, 1);
        cyc(1, 8'h01, 1, 0);
        @(negedge clk);
        chk("midrst_sig",   32'(out_sig_a),   32'd0);
        chk("midrst_cnt",   32'(out_count_a), 32'd0);
        chk("midrst_ready", {31'b0, in_ready_a}, 32'd1);
        chk("midrst_busy",  {31'b0, busy_a},     32'd0);
        cyc(0, 8'h00, 0, 0);
        pin(16'h0001, 1, 1);
        cyc(0, 8'h00, 0, 1);

        // six-beat bursts: count saturates at 3 on the 2-bit instance; golden match then mismatch
        for (int f = 0; f < 2; f++) begin
            flip = f[0];
            for (int k = 1; k <= 6; k++) cyc(1, 8'(k), k == 6, 0);
            cyc(0, 8'h00, 0, 0);
            pin(16'h0004, 6, 3);
            cyc(0, 8'h00, 0, 1);
        end

        for (int n = 0; n < 4000; n++) begin
            flip = ($urandom % 2) == 0;
            cyc(($urandom % 10) < 7, 8'($urandom), ($urandom % 4) == 0,
                ($urandom % 2) == 0, ($urandom % 250) == 0);
        end
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
